// File: rtl/frame_renderer.sv
// Drawing engine feeding the VGA stage: it owns the 80x60 back/front framebuffers,
// runs FILL/RECT/SWAP commands and presents the front buffer as a flat pixel bus.
module frame_renderer #(
   parameter int COLS = 80,
   parameter int ROWS = 60,
   parameter int CW   = 3
) (
   input  logic                     dclk,
   input  logic                     clr,
   input  logic                     vsync,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [6:0]               cmd_x0,
   input  logic [5:0]               cmd_y0,
   input  logic [6:0]               cmd_x1,
   input  logic [5:0]               cmd_y1,
   input  logic [CW-1:0]            cmd_color,
   output logic                     busy,
   output logic                     swap_done,
   output logic [COLS*ROWS*CW:0]    pixel
);

   localparam int CELLS = COLS * ROWS;
   localparam int FBW   = CELLS * CW;
   localparam int IDXW  = $clog2(CELLS);
   localparam int BITW  = $clog2(FBW);

   localparam logic [1:0] OP_FILL = 2'd0;
   localparam logic [1:0] OP_RECT = 2'd1;
   localparam logic [1:0] OP_SWAP = 2'd2;

   localparam logic [6:0] MAX_X = 7'(COLS - 1);
   localparam logic [5:0] MAX_Y = 6'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RECT,
      WAIT_VS
   } stateT;

   stateT              state;
   stateT              nextState;
   logic [FBW-1:0]     frontBuf;
   logic [FBW-1:0]     backBuf;
   logic               vsyncQ;
   logic               swapDone;
   logic [6:0]         rectX0;
   logic [6:0]         rectX1;
   logic [5:0]         rectY0;
   logic [5:0]         rectY1;
   logic [6:0]         curX;
   logic [5:0]         curY;
   logic [CW-1:0]      drawColor;
   logic [6:0]         clipX1;
   logic [5:0]         clipY1;
   logic               rectEmpty;
   logic               lastCell;
   logic               vsFall;
   logic               accept;
   logic               writeEn;
   logic               isFill;
   logic [IDXW-1:0]    cellIdx;
   logic [BITW-1:0]    bitBase;

   // A FILL is just a rectangle covering the whole screen, so both draw states
   // share the clipped bounds and raster pointer below. Clipping only ever pulls
   // the far corner in; a start corner off-screen makes the rectangle empty.
   assign clipX1    = (rectX1 > MAX_X) ? MAX_X : rectX1;
   assign clipY1    = (rectY1 > MAX_Y) ? MAX_Y : rectY1;
   assign rectEmpty = (rectX0 > clipX1) || (rectY0 > clipY1) ||
                      (rectX0 > MAX_X)  || (rectY0 > MAX_Y);
   assign lastCell  = (curX == clipX1) && (curY == clipY1);
   assign vsFall    = vsyncQ && !vsync;
   assign accept    = cmd_valid && cmd_ready;
   assign isFill    = (cmd_op == OP_FILL);
   assign cellIdx   = IDXW'(curY) * IDXW'(COLS) + IDXW'(curX);
   assign bitBase   = BITW'(cellIdx) * BITW'(CW);

   assign busy      = (state != IDLE);
   assign swap_done = swapDone;
   assign pixel     = {1'b0, frontBuf};

   // State register; clr drops any in-flight operation straight back to IDLE.
   always_ff @(posedge dclk) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake logic. Commands are only taken in IDLE, and NOP
   // is accepted but leaves the engine idle. Each draw cycle writes one cell
   // unless the clipped rectangle turned out empty, which costs a single cycle.
   always_comb begin
      nextState = state;
      cmd_ready = 1'b0;
      writeEn   = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = !clr;
            if (cmd_valid && !clr) begin
               case (cmd_op)
                  OP_FILL: nextState = FILL;
                  OP_RECT: nextState = RECT;
                  OP_SWAP: nextState = WAIT_VS;
                  default: nextState = IDLE;
               endcase
            end
         end
         FILL, RECT: begin
            if (rectEmpty) begin
               nextState = IDLE;
            end else begin
               writeEn = 1'b1;
               if (lastCell) begin
                  nextState = IDLE;
               end
            end
         end
         WAIT_VS: begin
            if (vsFall) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath: operand latch, raster walk over the back buffer, and the
   // whole-frame copy to the front buffer on the vsync falling edge. The back
   // buffer is left intact by a swap so drawing can be incremental.
   always_ff @(posedge dclk) begin
      if (clr) begin
         frontBuf  <= '0;
         backBuf   <= '0;
         vsyncQ    <= 1'b1;
         swapDone  <= 1'b0;
         rectX0    <= '0;
         rectX1    <= '0;
         rectY0    <= '0;
         rectY1    <= '0;
         curX      <= '0;
         curY      <= '0;
         drawColor <= '0;
      end else begin
         vsyncQ   <= vsync;
         swapDone <= 1'b0;
         if (accept) begin
            rectX0    <= isFill ? 7'd0  : cmd_x0;
            rectY0    <= isFill ? 6'd0  : cmd_y0;
            rectX1    <= isFill ? MAX_X : cmd_x1;
            rectY1    <= isFill ? MAX_Y : cmd_y1;
            curX      <= isFill ? 7'd0  : cmd_x0;
            curY      <= isFill ? 6'd0  : cmd_y0;
            drawColor <= cmd_color;
         end
         if (writeEn) begin
            backBuf[bitBase +: CW] <= drawColor;
            if (curX == clipX1) begin
               curX <= rectX0;
               curY <= curY + 6'd1;
            end else begin
               curX <= curX + 7'd1;
            end
         end
         if (state == WAIT_VS && vsFall) begin
            frontBuf <= backBuf;
            swapDone <= 1'b1;
         end
      end
   end

endmodule
